// File: rtl/standard_demux_buf.sv
// Registered 1-to-2 stream demultiplexer: each accepted word is routed by in_3
// into one of two independent FIFOs, each drained through its own valid/ready port.
module standard_demux_buf #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_1,
    input  logic             in_3,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_1,
    output logic             out_1_valid,
    input  logic             out_1_ready,
    output logic [WIDTH-1:0] out_2,
    output logic             out_2_valid,
    input  logic             out_2_ready,
    output logic [CW-1:0]    cnt_1,
    output logic [CW-1:0]    cnt_2
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem     [2][DEPTH];
    logic [AW-1:0]    wr_ptr  [2];
    logic [AW-1:0]    rd_ptr  [2];
    logic [CW-1:0]    cnt     [2];
    logic [AW-1:0]    head_idx[2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       vld;
    logic [1:0]       rdy;

    // Readiness depends only on the registered count of the selected channel,
    // so a full FIFO refuses input even while it is being popped.
    assign in_ready = in_3 ? (cnt[1] != CW'(DEPTH)) : (cnt[0] != CW'(DEPTH));

    assign push[0] = in_valid & in_ready & ~in_3;
    assign push[1] = in_valid & in_ready & in_3;
    assign rdy     = {out_2_ready, out_1_ready};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            vld[k] = (cnt[k] != '0);
            pop[k] = vld[k] & rdy[k];
            // When empty, keep presenting the most recently popped word.
            head_idx[k] = vld[k] ? rd_ptr[k] : (rd_ptr[k] - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[k][i] <= '0;
                end
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    mem[k][wr_ptr[k]] <= in_1;
                    wr_ptr[k]         <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                case ({push[k], pop[k]})
                    2'b10:   cnt[k] <= cnt[k] + 1'b1;
                    2'b01:   cnt[k] <= cnt[k] - 1'b1;
                    default: cnt[k] <= cnt[k];
                endcase
            end
        end
    end

    assign out_1       = mem[0][head_idx[0]];
    assign out_2       = mem[1][head_idx[1]];
    assign out_1_valid = vld[0];
    assign out_2_valid = vld[1];
    assign cnt_1       = cnt[0];
    assign cnt_2       = cnt[1];

endmodule

// File: tb/tb_standard_demux_buf.sv
// Directed self-checking bench for standard_demux_buf (WIDTH=4, DEPTH=2).
module tb_standard_demux_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_1;
    logic       in_3;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_1;
    logic       out_1_valid;
    logic       out_1_ready;
    logic [3:0] out_2;
    logic       out_2_valid;
    logic       out_2_ready;
    logic [1:0] cnt_1;
    logic [1:0] cnt_2;

    int n_checks = 0;
    int n_fail   = 0;

    standard_demux_buf #(.WIDTH(4), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_1(in_1), .in_3(in_3), .in_valid(in_valid), .in_ready(in_ready),
        .out_1(out_1), .out_1_valid(out_1_valid), .out_1_ready(out_1_ready),
        .out_2(out_2), .out_2_valid(out_2_valid), .out_2_ready(out_2_ready),
        .cnt_1(cnt_1), .cnt_2(cnt_2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_1 = 4'h0; in_3 = 1'b0;
        out_1_ready = 1'b0; out_2_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_1_valid !== 1'b0 || out_2_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b%b want 00", out_1_valid, out_2_valid); end
        n_checks++; if (out_1 !== 4'h0 || out_2 !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h %h want 0 0", out_1, out_2); end
        n_checks++; if (cnt_1 !== 2'd0 || cnt_2 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d %0d want 0 0", cnt_1, cnt_2); end
    endtask

    task automatic test_routing();
        in_valid = 1'b1; in_1 = 4'h5; in_3 = 1'b0;
        step();
        n_checks++; if (out_1_valid !== 1'b1 || out_1 !== 4'h5 || cnt_1 !== 2'd1) begin n_fail++; $display("FAIL route_ch1: got v=%b d=%h c=%0d want v=1 d=5 c=1", out_1_valid, out_1, cnt_1); end
        n_checks++; if (out_2_valid !== 1'b0) begin n_fail++; $display("FAIL route_ch2_early: got v=%b want 0", out_2_valid); end
        in_1 = 4'h4; in_3 = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_2_valid !== 1'b1 || out_2 !== 4'h4 || cnt_2 !== 2'd1) begin n_fail++; $display("FAIL route_ch2: got v=%b d=%h c=%0d want v=1 d=4 c=1", out_2_valid, out_2, cnt_2); end
        n_checks++; if (out_1 !== 4'h5 || cnt_1 !== 2'd1) begin n_fail++; $display("FAIL route_ch1_hold: got d=%h c=%0d want d=5 c=1", out_1, cnt_1); end
        out_1_ready = 1'b1; out_2_ready = 1'b1;
        step();
        out_1_ready = 1'b0; out_2_ready = 1'b0;
        n_checks++; if (cnt_1 !== 2'd0 || cnt_2 !== 2'd0 || out_1_valid !== 1'b0 || out_2_valid !== 1'b0) begin n_fail++; $display("FAIL route_drain: got c=%0d %0d v=%b%b want 0 0 00", cnt_1, cnt_2, out_1_valid, out_2_valid); end
    endtask

    task automatic test_full();
        in_valid = 1'b1; in_3 = 1'b0; in_1 = 4'h1;
        step();
        in_1 = 4'h2;
        step();
        in_1 = 4'h3;
        #1;
        n_checks++; if (cnt_1 !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_block: got c=%0d rdy=%b want c=2 rdy=0", cnt_1, in_ready); end
        step();
        n_checks++; if (cnt_1 !== 2'd2 || out_1 !== 4'h1) begin n_fail++; $display("FAIL full_hold: got c=%0d d=%h want c=2 d=1", cnt_1, out_1); end
        in_3 = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_other_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (cnt_2 !== 2'd1 || out_2 !== 4'h3 || out_2_valid !== 1'b1) begin n_fail++; $display("FAIL full_other_push: got c=%0d d=%h v=%b want c=1 d=3 v=1", cnt_2, out_2, out_2_valid); end
    endtask

    task automatic test_drain();
        // Channel 1 full: a push while popping must still be refused.
        out_1_ready = 1'b1; in_valid = 1'b1; in_3 = 1'b0; in_1 = 4'hE;
        #1;
        n_checks++; if (out_1 !== 4'h1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_first: got d=%h rdy=%b want d=1 rdy=0", out_1, in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (out_1 !== 4'h2 || cnt_1 !== 2'd1 || out_1_valid !== 1'b1) begin n_fail++; $display("FAIL drain_second: got d=%h c=%0d v=%b want d=2 c=1 v=1", out_1, cnt_1, out_1_valid); end
        step();
        out_1_ready = 1'b0;
        n_checks++; if (out_1_valid !== 1'b0 || cnt_1 !== 2'd0) begin n_fail++; $display("FAIL drain_empty: got v=%b c=%0d want v=0 c=0", out_1_valid, cnt_1); end
        n_checks++; if (out_1 !== 4'h2) begin n_fail++; $display("FAIL drain_stable: got %h want 2", out_1); end
        step();
        n_checks++; if (out_1_valid !== 1'b0 || cnt_1 !== 2'd0 || cnt_2 !== 2'd1) begin n_fail++; $display("FAIL drain_idle_ready: got v=%b c=%0d %0d want v=0 c=0 1", out_1_valid, cnt_1, cnt_2); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_head;
        in_valid = 1'b1; in_3 = 1'b1; out_2_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_1 = 4'hA + 4'(i);
            exp_head = (i == 0) ? 4'h3 : (4'hA + 4'(i - 1));
            #1;
            n_checks++; if (out_2 !== exp_head || in_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_head[%0d]: got d=%h rdy=%b want d=%h rdy=1", i, out_2, in_ready, exp_head); end
            step();
            n_checks++; if (cnt_2 !== 2'd1) begin n_fail++; $display("FAIL pushpop_cnt[%0d]: got %0d want 1", i, cnt_2); end
        end
        in_valid = 1'b0; out_2_ready = 1'b0;
        #1;
        n_checks++; if (out_2 !== 4'hF || out_2_valid !== 1'b1) begin n_fail++; $display("FAIL pushpop_last: got d=%h v=%b want d=f v=1", out_2, out_2_valid); end
        out_2_ready = 1'b1;
        step();
        out_2_ready = 1'b0;
        n_checks++; if (cnt_2 !== 2'd0 || out_2_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty: got c=%0d v=%b want 0 0", cnt_2, out_2_valid); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        in_3 = 1'b0; in_1 = 4'h7; step();
        in_1 = 4'h8; step();
        in_3 = 1'b1; in_1 = 4'h9; step();
        in_1 = 4'h6; step();
        in_valid = 1'b0;
        n_checks++; if (cnt_1 !== 2'd2 || cnt_2 !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full: got c=%0d %0d rdy=%b want 2 2 0", cnt_1, cnt_2, in_ready); end
        rst = 1'b1; out_1_ready = 1'b1; out_2_ready = 1'b1;
        step();
        rst = 1'b0; out_1_ready = 1'b0; out_2_ready = 1'b0;
        #1;
        n_checks++; if (cnt_1 !== 2'd0 || cnt_2 !== 2'd0 || out_1_valid !== 1'b0 || out_2_valid !== 1'b0) begin n_fail++; $display("FAIL mid_cleared: got c=%0d %0d v=%b%b want 0 0 00", cnt_1, cnt_2, out_1_valid, out_2_valid); end
        n_checks++; if (in_ready !== 1'b1 || out_1 !== 4'h0 || out_2 !== 4'h0) begin n_fail++; $display("FAIL mid_ready_data: got rdy=%b d=%h %h want 1 0 0", in_ready, out_1, out_2); end
        in_valid = 1'b1; in_3 = 1'b0; in_1 = 4'hC;
        step();
        in_valid = 1'b0;
        n_checks++; if (out_1 !== 4'hC || cnt_1 !== 2'd1 || out_2_valid !== 1'b0) begin n_fail++; $display("FAIL mid_fresh: got d=%h c=%0d v2=%b want d=c c=1 v2=0", out_1, cnt_1, out_2_valid); end
        out_1_ready = 1'b1;
        step();
        out_1_ready = 1'b0;
        n_checks++; if (out_1_valid !== 1'b0 || cnt_1 !== 2'd0) begin n_fail++; $display("FAIL mid_no_stale: got v=%b c=%0d want 0 0", out_1_valid, cnt_1); end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_full();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/standard_demux_buf.md
Name: standard_demux_buf

Overview:
- Registered 1-to-2 stream demultiplexer: the inverse of the team's 2:1 standard mux.
- Takes one WIDTH-bit input stream with a select bit and routes each accepted word to one of two output channels.
- Each output channel has its own small FIFO and a valid/ready handshake.
- Sits downstream of a standard_mux, or anywhere a shared bus must fan out to two consumers without blocking the idle one's data.

Parameters:
WIDTH, 4, data width of input and both outputs
DEPTH, 2, entries per output FIFO; power of 2, >= 2
CW, $clog2(DEPTH)+1, width of occupancy counters (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_1  input  WIDTH  input data word
in_3  input  1  channel select: 0 -> channel 1, 1 -> channel 2 (same sense as standard mux select)
in_valid  input  1  in_1/in_3 hold a valid word
in_ready  output  1  selected channel can accept this cycle
out_1  output  WIDTH  channel 1 head-of-FIFO data
out_1_valid  output  1  channel 1 FIFO non-empty
out_1_ready  input  1  channel 1 consumer accepts head
out_2  output  WIDTH  channel 2 head-of-FIFO data
out_2_valid  output  1  channel 2 FIFO non-empty
out_2_ready  input  1  channel 2 consumer accepts head
cnt_1  output  CW  channel 1 occupancy, 0..DEPTH
cnt_2  output  CW  channel 2 occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at posedge):
  - both FIFOs emptied: pointers=0, cnt_1=cnt_2=0.
  - out_1_valid=out_2_valid=0.
  - out_1=out_2=0 (storage cleared).
  - in_ready then reflects empty FIFOs, i.e. 1.
  - Reset mid-operation discards all stored words; no pops complete in the reset cycle.
- in_ready: in_3 ? (cnt_2 != DEPTH) : (cnt_1 != DEPTH).
  - Combinational from in_3 and registered counts only.
  - No path from out_k_ready to in_ready.
  - A full FIFO does not accept even if it is being popped that cycle.
- Input transfer: in_valid & in_ready at posedge. in_1 is written to the tail of the FIFO chosen by in_3; that count increments.
- Output transfer: out_k_valid & out_k_ready at posedge. Head is removed and count decrements.
  - out_k_ready while out_k_valid=0 has no effect.
- Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
- Push into an empty FIFO: out_k_valid=1 and out_k=word on the cycle after acceptance (1-cycle latency). No same-cycle bypass.
- Other channel unaffected: channel 2 may drain while channel 1 is full and blocking input.
- Input is in-order per channel. Words to different channels have no ordering relation.
- Pointers wrap modulo DEPTH. Count saturates logically at DEPTH via in_ready; never overflows or underflows.
- out_k is the head entry whenever out_k_valid=1. Value is don't-care-but-stable (last head) when empty, except 0 after reset.
- in_valid=0: in_1 and in_3 are ignored.
- Implementation: one FSM-free FIFO per channel (storage array, rd/wr pointers, counter) plus the routing logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release -> in_ready=1, out_1_valid=out_2_valid=0, out_1=out_2=4'h0, cnt_1=cnt_2=0.
- Routing: push in_1=4'h5,in_3=0, then in_1=4'h4,in_3=1, out_k_ready=0.
  - out_1_valid=1, out_1=4'h5, cnt_1=1.
  - out_2_valid=1, out_2=4'h4, cnt_2=1.
  - Each appears one cycle after its acceptance.
- Full/backpressure: push 4'h1, 4'h2, 4'h3 to channel 1 with out_1_ready=0.
  - After two accepts, cnt_1=2 and in_ready=0 with in_3=0; 4'h3 is not accepted.
  - Switching in_3=1 gives in_ready=1 and 4'h3 enters channel 2.
- Drain order: from full channel 1 (4'h1, 4'h2), assert out_1_ready for 2 cycles -> out_1 shows 4'h1 then 4'h2, out_1_valid then 0, cnt_1=0.
- Simultaneous push/pop with wrap: channel 2 holding 1 word, push 4'hA while popping for 6 consecutive cycles (values A..F) -> cnt_2 stays 1, outputs emerge in order, pointers wrap without loss.
- Reset mid-stream: both FIFOs full, assert rst one cycle -> cnt_1=cnt_2=0, both valids 0, in_ready=1; stale words never reappear.
